// File: rtl/fifo_serializer.sv
// fifo_serializer: drains a synchronous FIFO one word at a time and transmits
// each word LSB-first on a single serial line, framed by a start bit (0) and a
// stop bit (1). Each serial bit lasts clks_per_bit clock cycles.
module fifo_serializer #(
    parameter int unsigned width        = 4,
    parameter int unsigned clks_per_bit = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             empty,
    input  logic [width-1:0] fifo_data,
    output logic             read,
    output logic             tx,
    output logic             busy,
    output logic             frame_done
);

    localparam int unsigned DIV_W = (clks_per_bit > 1) ? $clog2(clks_per_bit) : 1;
    localparam int unsigned BIT_W = $clog2(width + 1);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(clks_per_bit - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(width - 1);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] POP   = 3'd1;
    localparam logic [2:0] LOAD  = 3'd2;
    localparam logic [2:0] START = 3'd3;
    localparam logic [2:0] DATA  = 3'd4;
    localparam logic [2:0] STOP  = 3'd5;

    logic [2:0]       state, state_next;
    logic [DIV_W-1:0] div_cnt, div_next;
    logic [BIT_W-1:0] bit_idx, bit_idx_next;
    logic [width-1:0] shift, shift_next;

    logic read_next, tx_next, busy_next, frame_done_next;
    logic tick;

    // Last cycle of the current serial bit.
    assign tick = (div_cnt == DIV_LAST);

    // State, datapath and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            div_cnt    <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            read       <= 1'b0;
            tx         <= 1'b1;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_next;
            div_cnt    <= div_next;
            bit_idx    <= bit_idx_next;
            shift      <= shift_next;
            read       <= read_next;
            tx         <= tx_next;
            busy       <= busy_next;
            frame_done <= frame_done_next;
        end
    end

    // Next-state, datapath update and next output values.
    always_comb begin
        state_next      = state;
        div_next        = div_cnt;
        bit_idx_next    = bit_idx;
        shift_next      = shift;
        read_next       = 1'b0;
        tx_next         = 1'b1;
        busy_next       = 1'b0;
        frame_done_next = 1'b0;

        case (state)
            IDLE: begin
                div_next = '0;
                if (en && !empty) begin
                    state_next = POP;
                end
            end
            POP: begin
                div_next   = '0;
                state_next = LOAD;
            end
            LOAD: begin
                div_next   = '0;
                shift_next = fifo_data;
                state_next = START;
            end
            START: begin
                if (tick) begin
                    div_next     = '0;
                    bit_idx_next = '0;
                    state_next   = DATA;
                end else begin
                    div_next = div_cnt + DIV_W'(1);
                end
            end
            DATA: begin
                if (tick) begin
                    div_next   = '0;
                    shift_next = shift >> 1;
                    if (bit_idx == BIT_LAST) begin
                        bit_idx_next = '0;
                        state_next   = STOP;
                    end else begin
                        bit_idx_next = bit_idx + BIT_W'(1);
                    end
                end else begin
                    div_next = div_cnt + DIV_W'(1);
                end
            end
            STOP: begin
                if (tick) begin
                    div_next = '0;
                    if (en && !empty) begin
                        state_next = POP;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    div_next = div_cnt + DIV_W'(1);
                end
            end
            default: begin
                state_next   = IDLE;
                div_next     = '0;
                bit_idx_next = '0;
            end
        endcase

        // Outputs are precomputed from the next state so they register glitch-free.
        read_next       = (state_next == POP);
        busy_next       = (state_next != IDLE);
        frame_done_next = (state_next == STOP) && (div_next == DIV_LAST);
        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shift_next[0];
            default: tx_next = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_fifo_serializer.sv
// Testbench for fifo_serializer: two instances (4-bit/4 clocks-per-bit and
// 8-bit/1 clock-per-bit), a FIFO model per instance and a scoreboard of words.
module tb_fifo_serializer;

    logic clk = 1'b0;
    logic rst;

    logic       en4, empty4, read4, tx4, busy4, fd4;
    logic [3:0] data4;
    logic       en8, empty8, read8, tx8, busy8, fd8;
    logic [7:0] data8;

    always #5 clk = ~clk;

    fifo_serializer #(.width(4), .clks_per_bit(4)) dut4 (
        .clk(clk), .rst(rst), .en(en4), .empty(empty4), .fifo_data(data4),
        .read(read4), .tx(tx4), .busy(busy4), .frame_done(fd4)
    );

    fifo_serializer #(.width(8), .clks_per_bit(1)) dut8 (
        .clk(clk), .rst(rst), .en(en8), .empty(empty8), .fifo_data(data8),
        .read(read8), .tx(tx8), .busy(busy8), .frame_done(fd8)
    );

    int n_assert = 0;
    int n_fail   = 0;

    logic [7:0] fq0[$];
    logic [7:0] fq1[$];
    logic [7:0] eq0[$];
    logic [7:0] eq1[$];

    int         fi[2];
    int         nreads[2];
    int         b2b[2];
    logic [7:0] cur[2];
    logic [7:0] dec[2];
    logic       rd_s[2];

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Expected tx level at cycle f of a frame (f=1 is the POP cycle).
    function automatic logic exp_tx(input int f, input int w, input int c, input logic [7:0] word);
        int b;
        if (f <= 2) return 1'b1;
        b = (f - 3) / c;
        if (b == 0) return 1'b0;
        if (b <= w) return word[b-1];
        return 1'b1;
    endfunction

    task automatic push(input int d, input logic [7:0] w);
        if (d == 0) begin
            fq0.push_back(w);
            eq0.push_back(w);
            empty4 = 1'b0;
        end else begin
            fq1.push_back(w);
            eq1.push_back(w);
            empty8 = 1'b0;
        end
    endtask

    // Per-cycle monitor: FIFO model service, frame tracking and checks.
    task automatic mon(input int d, input logic rd, input logic txv, input logic bz, input logic fd);
        int w, c, len, b, sz;
        logic [7:0] word;
        w   = (d == 0) ? 4 : 8;
        c   = (d == 0) ? 4 : 1;
        len = 2 + (w + 2) * c;
        rd_s[d] = rd;
        if (rd) begin
            check($sformatf("read_gap%0d", d), 8'(fi[d] == 0 || fi[d] == len), 8'd1);
            if (fi[d] == len) b2b[d]++;
            sz = (d == 0) ? fq0.size() : fq1.size();
            check($sformatf("nonempty_at_pop%0d", d), 8'(sz != 0), 8'd1);
            word = 8'd0;
            if (d == 0) begin
                if (fq0.size() != 0) word = fq0.pop_front();
                if (eq0.size() != 0) cur[0] = eq0.pop_front();
                data4  = word[3:0];
                empty4 = (fq0.size() == 0);
            end else begin
                if (fq1.size() != 0) word = fq1.pop_front();
                if (eq1.size() != 0) cur[1] = eq1.pop_front();
                data8  = word;
                empty8 = (fq1.size() == 0);
            end
            nreads[d]++;
            fi[d]  = 1;
            dec[d] = 8'd0;
        end else if (fi[d] != 0) begin
            fi[d] = (fi[d] == len) ? 0 : fi[d] + 1;
        end

        if (fi[d] != 0) begin
            check($sformatf("tx%0d_f%0d", d, fi[d]), 8'(txv), 8'(exp_tx(fi[d], w, c, cur[d])));
            check($sformatf("busy%0d_f%0d", d, fi[d]), 8'(bz), 8'd1);
            check($sformatf("frame_done%0d_f%0d", d, fi[d]), 8'(fd), 8'(fi[d] == len));
            if (fi[d] >= 3) begin
                b = (fi[d] - 3) / c;
                if (((fi[d] - 3) % c) == (c / 2) && b >= 1 && b <= w) dec[d][b-1] = txv;
            end
            if (fi[d] == len) check($sformatf("decode%0d", d), dec[d], cur[d]);
        end else begin
            check($sformatf("idle_tx%0d", d), 8'(txv), 8'd1);
            check($sformatf("idle_busy%0d", d), 8'(bz), 8'd0);
            check($sformatf("idle_frame_done%0d", d), 8'(fd), 8'd0);
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        mon(0, read4, tx4, busy4, fd4);
        mon(1, read8, tx8, busy8, fd8);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic wait_read(input int d, input string tag);
        int n0;
        n0 = nreads[d];
        for (int i = 0; i < 100 && nreads[d] == n0; i++) cycle();
        check(tag, 8'(nreads[d] != n0), 8'd1);
    endtask

    initial begin
        int n;
        for (int i = 0; i < 2; i++) begin
            fi[i] = 0; nreads[i] = 0; b2b[i] = 0; cur[i] = 8'd0; dec[i] = 8'd0; rd_s[i] = 1'b0;
        end
        rst    = 1'b0;
        en4    = 1'b1;
        en8    = 1'b0;
        empty4 = 1'b1;
        empty8 = 1'b1;
        data4  = 4'd0;
        data8  = 8'd0;

        // Reset with a word waiting and en high; outputs hold idle values.
        push(0, 8'hA);
        cycle();
        check("rst_read", 8'(read4), 8'd0);
        cycle();
        check("rst_tx", 8'(tx4), 8'd1);
        check("rst_busy", 8'(busy4), 8'd0);
        rst = 1'b1;
        cycle();
        check("first_read_after_release", 8'(rd_s[0]), 8'd1);

        // Single word 1010 serialized and back to idle.
        run(30);
        check("single_word_reads", 8'(nreads[0]), 8'd1);

        // Back-to-back frames 1,2,3.
        push(0, 8'h1);
        push(0, 8'h2);
        push(0, 8'h3);
        run(3 * 26 + 10);
        check("b2b_reads", 8'(nreads[0]), 8'd4);
        check("b2b_adjacent", 8'(b2b[0]), 8'd2);
        check("b2b_scoreboard_empty", 8'(eq0.size()), 8'd0);

        // en low with data waiting: no read.
        en4 = 1'b0;
        push(0, 8'h6);
        run(50);
        check("gated_no_read", 8'(nreads[0]), 8'd4);

        // en high drains the word, then an empty FIFO gives no read.
        en4 = 1'b1;
        wait_read(0, "gated_release_read");
        run(60);
        check("empty_no_read", 8'(nreads[0]), 8'd5);

        // en dropped mid-frame: frame completes, next word stays queued.
        push(0, 8'h9);
        push(0, 8'hF);
        wait_read(0, "midframe_read");
        run(9);
        en4 = 1'b0;
        run(40);
        check("en_drop_reads", 8'(nreads[0]), 8'd6);
        check("en_drop_fifo_left", 8'(fq0.size()), 8'd1);

        // Reset during DATA bit 2 of word F.
        en4 = 1'b1;
        wait_read(0, "reset_word_read");
        run(15);
        check("reset_point_frame_cycle", 8'(fi[0]), 8'd16);
        #2 rst = 1'b0;
        #1;
        check("async_rst_tx", 8'(tx4), 8'd1);
        check("async_rst_busy", 8'(busy4), 8'd0);
        check("async_rst_read", 8'(read4), 8'd0);
        fi[0] = 0;
        push(0, 8'h5);
        run(2);
        rst = 1'b1;
        n = nreads[0];
        cycle();
        check("post_reset_read", 8'(nreads[0] - n), 8'd1);
        run(30);
        check("post_reset_reads", 8'(nreads[0]), 8'd8);

        // One cycle per bit, 8-bit word A5.
        push(1, 8'hA5);
        en8 = 1'b1;
        wait_read(1, "w8_read");
        run(15);
        check("w8_reads", 8'(nreads[1]), 8'd1);
        check("w8_scoreboard_empty", 8'(eq1.size()), 8'd0);
        check("final_scoreboard_empty", 8'(eq0.size()), 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
